// File: rtl/ram_port_arbiter.sv
// Shares one simple dual-port coefficient RAM between NUM_REQ requesters.
// The write port and the read port each have their own round-robin arbiter; read data is routed back by tag.
module ram_port_arbiter #(
   parameter int MEM_WIDTH = 32,
   parameter int MEM_DEPTH = 1024,
   parameter int NUM_REQ   = 2,
   localparam int AW = $clog2(MEM_DEPTH),
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_write,
   input  logic [NUM_REQ*AW-1:0]        req_addr,
   input  logic [NUM_REQ*MEM_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [MEM_WIDTH-1:0]         rsp_data,
   output logic                         en_a,
   output logic                         write_en_a,
   output logic [AW-1:0]                addr_a,
   output logic [MEM_WIDTH-1:0]         data_in_a,
   output logic                         en_b,
   output logic [AW-1:0]                addr_b,
   input  logic [MEM_WIDTH-1:0]         data_out_b
);

   logic [IW-1:0]      wr_ptr, rd_ptr, tag;
   logic               pending;
   logic [IW:0]        wr_pick, rd_pick;
   logic               wr_found, rd_found;
   logic [IW-1:0]      wr_gnt, rd_gnt;
   logic [NUM_REQ-1:0] wr_oh, rd_oh;

   // Returns {found, index} of the first candidate at or after ptr, wrapping.
   function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                           input logic [IW-1:0] ptr);
      logic [IW:0]   res;
      logic [IW-1:0] sel;
      int unsigned   idx;
      res = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = k + 32'(ptr);
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = IW'(idx);
         if (!res[IW] && cand[sel]) res = {1'b1, sel};
      end
      return res;
   endfunction

   function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
      return (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
   endfunction

   always_comb begin
      wr_pick    = rr_pick(req_valid & req_write, wr_ptr);
      rd_pick    = rr_pick(req_valid & ~req_write, rd_ptr);
      // Grants are gated by reset_n so the RAM sees no enables while reset is asserted.
      wr_found   = reset_n & wr_pick[IW];
      rd_found   = reset_n & rd_pick[IW];
      wr_gnt     = wr_pick[IW-1:0];
      rd_gnt     = rd_pick[IW-1:0];
      wr_oh      = wr_found ? (NUM_REQ'(1) << wr_gnt) : '0;
      rd_oh      = rd_found ? (NUM_REQ'(1) << rd_gnt) : '0;
      req_ready  = wr_oh | rd_oh;
      en_a       = wr_found;
      write_en_a = wr_found;
      en_b       = rd_found;
      addr_a     = '0;
      data_in_a  = '0;
      addr_b     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (wr_oh[i]) begin
            addr_a    = req_addr[i*AW +: AW];
            data_in_a = req_wdata[i*MEM_WIDTH +: MEM_WIDTH];
         end
         if (rd_oh[i]) addr_b = req_addr[i*AW +: AW];
      end
      rsp_valid  = pending ? (NUM_REQ'(1) << tag) : '0;
      rsp_data   = data_out_b;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag     <= '0;
         pending <= 1'b0;
      end else begin
         if (wr_found) wr_ptr <= next_ptr(wr_gnt);
         if (rd_found) begin
            rd_ptr <= next_ptr(rd_gnt);
            tag    <= rd_gnt;
         end
         pending <= rd_found;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1-cycle-latency RAM attached.
module tb_ram_port_arbiter;
   localparam int MW = 32;
   localparam int AW = 10;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [1:0]    req_valid, req_write, req_ready, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*MW-1:0] req_wdata;
   logic [MW-1:0] rsp_data, data_in_a, data_out_b;
   logic          en_a, write_en_a, en_b;
   logic [AW-1:0] addr_a, addr_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [MW-1:0] mem [0:1023];
   bit            mem_init = 1'b0;

   ram_port_arbiter #(.MEM_WIDTH(MW), .MEM_DEPTH(1024), .NUM_REQ(2)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .en_a(en_a), .write_en_a(write_en_a),
      .addr_a(addr_a), .data_in_a(data_in_a), .en_b(en_b), .addr_b(addr_b),
      .data_out_b(data_out_b)
   );

   always #5 clock = ~clock;

   // RAM model: preloaded with 0x1000_0000 + address, read returns the pre-write word.
   always @(posedge clock) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
         mem_init <= 1'b1;
      end else if (en_a && write_en_a) mem[addr_a] <= data_in_a;
      if (en_b) data_out_b <= mem[addr_b];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input bit v, input bit w,
                          input logic [AW-1:0] a, input logic [MW-1:0] d);
      req_valid[i] = v;
      req_write[i] = w;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*MW +: MW] = d;
   endtask

   task automatic idle();
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
   endtask

   // advance one clock; returns at the falling edge where new inputs get driven
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic [MW-1:0] t5_exp(input int a);
      if (a == 3) return 32'h0000_1234;
      if (a == 5) return 32'hDEAD_BEEF;
      return 32'h1000_0000 + a;
   endfunction

   initial begin
      reset_n = 1'b0;
      set_req(0, 1'b1, 1'b1, 10'd10, 32'hAAAA_0000);
      set_req(1, 1'b1, 1'b0, 10'd11, 32'hBBBB_0000);
      repeat (3) @(negedge clock);
      #1;
      check("t1_ready", req_ready, 2'b00);
      check("t1_en_a", en_a, 1'b0);
      check("t1_en_b", en_b, 1'b0);
      check("t1_rsp_valid", rsp_valid, 2'b00);

      // release: both write, requester 0 wins
      reset_n = 1'b1;
      set_req(1, 1'b1, 1'b1, 10'd11, 32'hBBBB_0000);
      #1;
      check("t1_wr_ready", req_ready, 2'b01);
      check("t1_wr_en", {en_a, write_en_a, en_b}, 3'b110);
      check("t1_addr_a", addr_a, 10'd10);
      check("t1_data_a", data_in_a, 32'hAAAA_0000);
      tick();
      // both read, requester 0 wins
      set_req(0, 1'b1, 1'b0, 10'd10, '0);
      set_req(1, 1'b1, 1'b0, 10'd11, '0);
      #1;
      check("t1_rd_ready", req_ready, 2'b01);
      check("t1_rd_en", {en_a, en_b}, 2'b01);
      check("t1_addr_b", addr_b, 10'd10);
      check("t1_addr_a_idle", addr_a, 10'd0);
      tick();
      idle();
      #1;
      check("t1_rsp_valid2", rsp_valid, 2'b01);
      check("t1_rsp_data", rsp_data, 32'hAAAA_0000);

      // T2: write then read on a different requester
      set_req(0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
      #1;
      check("t2_wr_ready", req_ready, 2'b01);
      tick();
      idle();
      set_req(1, 1'b1, 1'b0, 10'd5, '0);
      #1;
      check("t2_rd_ready", req_ready, 2'b10);
      check("t2_addr_b", addr_b, 10'd5);
      tick();
      idle();
      #1;
      check("t2_rsp_valid", rsp_valid, 2'b10);
      check("t2_rsp_data", rsp_data, 32'hDEAD_BEEF);

      // wr_ptr is now 1; a lone requester-1 write returns it to 0
      set_req(1, 1'b1, 1'b1, 10'd100, 32'h0000_5555);
      #1;
      check("t3_pre_ready", req_ready, 2'b10);
      tick();

      // T3: write contention alternates 0,1,0,1
      set_req(0, 1'b1, 1'b1, 10'd200, 32'h0000_00A0);
      set_req(1, 1'b1, 1'b1, 10'd201, 32'h0000_00B1);
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("t3_ready_%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("t3_addr_a_%0d", k), addr_a, (k % 2 == 0) ? 10'd200 : 10'd201);
         tick();
      end
      idle();

      // T4: same-cycle read and write of address 3 from different requesters
      set_req(0, 1'b1, 1'b0, 10'd3, '0);
      set_req(1, 1'b1, 1'b1, 10'd3, 32'h0000_1234);
      #1;
      check("t4_ready", req_ready, 2'b11);
      check("t4_en", {en_a, en_b}, 2'b11);
      tick();
      idle();
      set_req(0, 1'b1, 1'b0, 10'd3, '0);
      #1;
      check("t4_rsp_valid_old", rsp_valid, 2'b01);
      check("t4_rsp_data_old", rsp_data, 32'h1000_0003);
      check("t4_reread_ready", req_ready, 2'b01);
      tick();
      idle();
      #1;
      check("t4_rsp_valid_new", rsp_valid, 2'b01);
      check("t4_rsp_data_new", rsp_data, 32'h0000_1234);

      // T5: back-to-back reads from requester 1
      for (int k = 0; k < 8; k++) begin
         set_req(1, 1'b1, 1'b0, AW'(k), '0);
         #1;
         check($sformatf("t5_ready_%0d", k), req_ready, 2'b10);
         if (k > 0) begin
            check($sformatf("t5_rsp_valid_%0d", k - 1), rsp_valid, 2'b10);
            check($sformatf("t5_rsp_data_%0d", k - 1), rsp_data, t5_exp(k - 1));
         end
         tick();
      end
      idle();
      #1;
      check("t5_rsp_valid_7", rsp_valid, 2'b10);
      check("t5_rsp_data_7", rsp_data, t5_exp(7));
      tick();
      #1;
      check("t5_rsp_idle", rsp_valid, 2'b00);

      // T6: reset right after a read grant (rd_ptr becomes 1 before reset)
      set_req(0, 1'b1, 1'b0, 10'd7, '0);
      #1;
      check("t6_ready", req_ready, 2'b01);
      tick();
      reset_n = 1'b0;
      idle();
      #1;
      check("t6_rsp_in_reset", rsp_valid, 2'b00);
      tick();
      reset_n = 1'b1;
      #1;
      check("t6_rsp_after_release", rsp_valid, 2'b00);
      tick();
      #1;
      check("t6_rsp_later", rsp_valid, 2'b00);
      set_req(0, 1'b1, 1'b0, 10'd1, '0);
      set_req(1, 1'b1, 1'b0, 10'd2, '0);
      #1;
      check("t6_rd_ptr_zero", req_ready, 2'b01);
      check("t6_addr_b", addr_b, 10'd1);
      tick();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
